// File: rtl/msg_sched_pkg.sv
// Shared types and width helpers for the message frame scheduler.
// Provides the scheduler state enum and counter width functions.
package msg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUN      = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    // Width able to index n values, never narrower than one bit.
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pc_w(input int pcode_len);
        return cw(pcode_len);
    endfunction

    function automatic int rep_w(input int pcode_repeats);
        return cw(pcode_repeats);
    endfunction

    function automatic int msg_w(input int message_len);
        return cw(message_len);
    endfunction

    // Holdover seconds count 0..max inclusive.
    function automatic int ho_w(input int max_holdover);
        return cw(max_holdover + 1);
    endfunction

endpackage

// File: rtl/pps_stretcher.sv
// Retriggerable PPS pulse stretcher: pps_out is high PPS_WIDTH cycles after trig.
// Ports: clk, rst (async high), trig (one-cycle request), pps_out (stretched pulse).
module pps_stretcher #(
    parameter int PPS_WIDTH = 4092000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pps_out
);

    localparam int CW = $clog2(PPS_WIDTH + 1);

    logic [CW-1:0] cnt;

    // A trigger while high reloads the full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (trig) begin
            cnt <= CW'(PPS_WIDTH);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign pps_out = (cnt != '0);

endmodule

// File: rtl/msg_frame_sched.sv
// PPS-locked frame scheduler with holdover: chip/repeat/bit addresses per channel frame.
// Ports: clk, rst, sys_time_sync_done, sys_pps, dac_valid, channel_enable in;
//        pcode_addr, rep_idx, msg_addr, ch_active, frame_start, running, holdover,
//        holdover_secs, pps_out out.
module msg_frame_sched
    import msg_sched_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int PCODE_LEN     = 40920,
    parameter int PCODE_REPEATS = 10,
    parameter int MESSAGE_LEN   = 120,
    parameter int PPS_WIDTH     = 4092000,
    parameter int MAX_HOLDOVER  = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sys_time_sync_done,
    input  logic                              sys_pps,
    input  logic                              dac_valid,
    input  logic [NUM_CH-1:0]                 channel_enable,
    output logic [pc_w(PCODE_LEN)-1:0]        pcode_addr,
    output logic [rep_w(PCODE_REPEATS)-1:0]   rep_idx,
    output logic [msg_w(MESSAGE_LEN)-1:0]     msg_addr,
    output logic [NUM_CH-1:0]                 ch_active,
    output logic                              frame_start,
    output logic                              running,
    output logic                              holdover,
    output logic [ho_w(MAX_HOLDOVER)-1:0]     holdover_secs,
    output logic                              pps_out
);

    localparam int PC_W  = pc_w(PCODE_LEN);
    localparam int REP_W = rep_w(PCODE_REPEATS);
    localparam int MSG_W = msg_w(MESSAGE_LEN);
    localparam int HO_W  = ho_w(MAX_HOLDOVER);

    localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(PCODE_LEN - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(PCODE_REPEATS - 1);
    localparam logic [MSG_W-1:0] MSG_MAX = MSG_W'(MESSAGE_LEN - 1);
    localparam logic [HO_W-1:0]  HO_MAX  = HO_W'(MAX_HOLDOVER);

    if (PCODE_LEN < 2 || PCODE_REPEATS < 2 || MESSAGE_LEN < 2 ||
        PPS_WIDTH < 1 || MAX_HOLDOVER < 1) begin : g_bad_params
        $error("msg_frame_sched: illegal parameter set");
    end

    state_t              state, state_n;
    logic [PC_W-1:0]     pc_n;
    logic [REP_W-1:0]    rep_n;
    logic [MSG_W-1:0]    msg_n;
    logic [HO_W-1:0]     ho_n;
    logic [NUM_CH-1:0]   act_n;
    logic                fs_n;
    logic                syn_pps;
    logic                pc_wrap, rep_wrap, msg_wrap;

    assign pc_wrap  = (pcode_addr == PC_MAX);
    assign rep_wrap = (rep_idx == REP_MAX);
    assign msg_wrap = (msg_addr == MSG_MAX);

    always_comb begin
        state_n = state;
        pc_n    = pcode_addr;
        rep_n   = rep_idx;
        msg_n   = msg_addr;
        ho_n    = holdover_secs;
        act_n   = ch_active;
        fs_n    = 1'b0;
        syn_pps = 1'b0;

        if (!sys_time_sync_done) begin
            state_n = IDLE;
            pc_n    = '0;
            rep_n   = '0;
            msg_n   = '0;
            ho_n    = '0;
            act_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ARMED;
                end
                ARMED: begin
                    if (sys_pps) begin
                        state_n = RUN;
                        fs_n    = 1'b1;
                        act_n   = channel_enable;
                    end
                end
                RUN, HOLDOVER: begin
                    if (sys_pps) begin
                        // Frame origin beats any simultaneous natural wrap.
                        state_n = RUN;
                        pc_n    = '0;
                        rep_n   = '0;
                        msg_n   = '0;
                        ho_n    = '0;
                        fs_n    = 1'b1;
                        act_n   = channel_enable;
                    end else if (dac_valid) begin
                        if (pc_wrap && rep_wrap && msg_wrap) begin
                            pc_n  = '0;
                            rep_n = '0;
                            msg_n = '0;
                            if (state == RUN) begin
                                state_n = HOLDOVER;
                                ho_n    = HO_W'(1);
                                syn_pps = 1'b1;
                                fs_n    = 1'b1;
                                act_n   = channel_enable;
                            end else if (holdover_secs < HO_MAX) begin
                                ho_n    = holdover_secs + 1'b1;
                                syn_pps = 1'b1;
                                fs_n    = 1'b1;
                                act_n   = channel_enable;
                            end else begin
                                // Holdover budget spent: drop lock.
                                state_n = IDLE;
                                ho_n    = '0;
                                act_n   = '0;
                            end
                        end else begin
                            pc_n = pc_wrap ? '0 : pcode_addr + 1'b1;
                            if (pc_wrap) begin
                                rep_n = rep_wrap ? '0 : rep_idx + 1'b1;
                            end
                            if (pc_wrap && rep_wrap) begin
                                msg_n = msg_addr + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pcode_addr    <= '0;
            rep_idx       <= '0;
            msg_addr      <= '0;
            holdover_secs <= '0;
            ch_active     <= '0;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_n;
            pcode_addr    <= pc_n;
            rep_idx       <= rep_n;
            msg_addr      <= msg_n;
            holdover_secs <= ho_n;
            ch_active     <= act_n;
            frame_start   <= fs_n;
        end
    end

    assign running  = (state == RUN) || (state == HOLDOVER);
    assign holdover = (state == HOLDOVER);

    pps_stretcher #(
        .PPS_WIDTH (PPS_WIDTH)
    ) u_pps (
        .clk     (clk),
        .rst     (rst),
        .trig    (sys_pps | syn_pps),
        .pps_out (pps_out)
    );

endmodule

// File: tb/tb_msg_frame_sched.sv
// Directed bench for msg_frame_sched with a reduced frame (4x2x3 chips).
// Drives lock, resync, holdover, enable latching, simultaneous origin and aborts.
module tb_msg_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       pps = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] en = 8'h00;

    logic [1:0] pcode_addr;
    logic [0:0] rep_idx;
    logic [1:0] msg_addr;
    logic [7:0] ch_active;
    logic       frame_start;
    logic       running;
    logic       holdover;
    logic [1:0] holdover_secs;
    logic       pps_out;

    int checks = 0;
    int failures = 0;

    msg_frame_sched #(
        .NUM_CH        (8),
        .PCODE_LEN     (4),
        .PCODE_REPEATS (2),
        .MESSAGE_LEN   (3),
        .PPS_WIDTH     (3),
        .MAX_HOLDOVER  (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sys_time_sync_done (sync),
        .sys_pps            (pps),
        .dac_valid          (dv),
        .channel_enable     (en),
        .pcode_addr         (pcode_addr),
        .rep_idx            (rep_idx),
        .msg_addr           (msg_addr),
        .ch_active          (ch_active),
        .frame_start        (frame_start),
        .running            (running),
        .holdover           (holdover),
        .holdover_secs      (holdover_secs),
        .pps_out            (pps_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        steps(2);
        chk("rst_pcode", 32'(pcode_addr), 0);
        chk("rst_rep", 32'(rep_idx), 0);
        chk("rst_msg", 32'(msg_addr), 0);
        chk("rst_act", 32'(ch_active), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_run", 32'(running), 0);
        chk("rst_ho", 32'(holdover), 0);
        chk("rst_secs", 32'(holdover_secs), 0);
        chk("rst_pps", 32'(pps_out), 0);
        rst = 1'b0;

        // Lock
        sync = 1'b1;
        en = 8'h0F;
        step();
        chk("armed_run", 32'(running), 0);
        chk("armed_fs", 32'(frame_start), 0);
        pps = 1'b1;
        step();
        pps = 1'b0;
        chk("lock_fs", 32'(frame_start), 1);
        chk("lock_run", 32'(running), 1);
        chk("lock_pc0", 32'(pcode_addr), 0);
        chk("lock_act", 32'(ch_active), 32'h0F);
        chk("lock_pps1", 32'(pps_out), 1);
        dv = 1'b1;
        step();
        chk("lock_pc1", 32'(pcode_addr), 1);
        chk("lock_fs_low", 32'(frame_start), 0);
        chk("lock_pps2", 32'(pps_out), 1);
        step();
        chk("lock_pc2", 32'(pcode_addr), 2);
        chk("lock_pps3", 32'(pps_out), 1);
        step();
        chk("lock_pc3", 32'(pcode_addr), 3);
        chk("lock_pps_end", 32'(pps_out), 0);
        step();
        chk("lock_pc_wrap", 32'(pcode_addr), 0);
        chk("lock_rep1", 32'(rep_idx), 1);
        steps(4);
        chk("lock_msg1", 32'(msg_addr), 1);
        chk("lock_rep0", 32'(rep_idx), 0);

        // Resync after 10 valids
        steps(2);
        chk("pre_resync_pc", 32'(pcode_addr), 2);
        pps = 1'b1;
        step();
        pps = 1'b0;
        chk("resync_pc", 32'(pcode_addr), 0);
        chk("resync_rep", 32'(rep_idx), 0);
        chk("resync_msg", 32'(msg_addr), 0);
        chk("resync_fs", 32'(frame_start), 1);
        chk("resync_ho", 32'(holdover), 0);
        step();
        chk("resync_fs_once", 32'(frame_start), 0);
        chk("resync_pc1", 32'(pcode_addr), 1);

        // Enable change mid-frame, then holdover entry
        en = 8'hF0;
        steps(3);
        chk("en_hold", 32'(ch_active), 32'h0F);
        steps(19);
        chk("max_pc", 32'(pcode_addr), 3);
        chk("max_rep", 32'(rep_idx), 1);
        chk("max_msg", 32'(msg_addr), 2);
        chk("en_hold_end", 32'(ch_active), 32'h0F);
        step();
        chk("ho1_ho", 32'(holdover), 1);
        chk("ho1_secs", 32'(holdover_secs), 1);
        chk("ho1_fs", 32'(frame_start), 1);
        chk("ho1_act", 32'(ch_active), 32'hF0);
        chk("ho1_pps", 32'(pps_out), 1);
        chk("ho1_run", 32'(running), 1);
        chk("ho1_pc", 32'(pcode_addr), 0);
        steps(23);
        chk("ho1_late_pps", 32'(pps_out), 0);
        step();
        chk("ho2_secs", 32'(holdover_secs), 2);
        chk("ho2_fs", 32'(frame_start), 1);
        chk("ho2_pps", 32'(pps_out), 1);
        steps(23);
        chk("ho2_late_secs", 32'(holdover_secs), 2);
        step();
        chk("hox_run", 32'(running), 0);
        chk("hox_ho", 32'(holdover), 0);
        chk("hox_pps", 32'(pps_out), 0);
        chk("hox_act", 32'(ch_active), 0);
        chk("hox_fs", 32'(frame_start), 0);
        chk("hox_secs", 32'(holdover_secs), 0);

        // Relock, then recover from holdover with sys_pps
        step();
        chk("rearm_run", 32'(running), 0);
        pps = 1'b1;
        step();
        pps = 1'b0;
        chk("relock_fs", 32'(frame_start), 1);
        chk("relock_act", 32'(ch_active), 32'hF0);
        steps(24);
        chk("reho_secs", 32'(holdover_secs), 1);
        chk("reho_ho", 32'(holdover), 1);
        steps(5);
        pps = 1'b1;
        step();
        pps = 1'b0;
        chk("recover_ho", 32'(holdover), 0);
        chk("recover_secs", 32'(holdover_secs), 0);
        chk("recover_fs", 32'(frame_start), 1);
        chk("recover_pc", 32'(pcode_addr), 0);
        chk("recover_run", 32'(running), 1);

        // sys_pps coincident with natural wrap
        steps(23);
        chk("sim_pre_pc", 32'(pcode_addr), 3);
        chk("sim_pre_msg", 32'(msg_addr), 2);
        pps = 1'b1;
        step();
        pps = 1'b0;
        chk("sim_fs", 32'(frame_start), 1);
        chk("sim_ho", 32'(holdover), 0);
        chk("sim_secs", 32'(holdover_secs), 0);
        chk("sim_pc", 32'(pcode_addr), 0);
        step();
        chk("sim_fs_once", 32'(frame_start), 0);
        chk("sim_ho_after", 32'(holdover), 0);
        chk("sim_pc1", 32'(pcode_addr), 1);

        // Sync loss mid-frame: pps_out finishes its pulse
        sync = 1'b0;
        step();
        chk("drop_run", 32'(running), 0);
        chk("drop_pc", 32'(pcode_addr), 0);
        chk("drop_act", 32'(ch_active), 0);
        chk("drop_pps_hold", 32'(pps_out), 1);
        step();
        chk("drop_pps_end", 32'(pps_out), 0);
        chk("drop_stays_idle", 32'(running), 0);

        // Asynchronous reset mid-frame
        sync = 1'b1;
        step();
        pps = 1'b1;
        step();
        pps = 1'b0;
        step();
        chk("pre_rst_pc", 32'(pcode_addr), 1);
        chk("pre_rst_pps", 32'(pps_out), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", 32'(pcode_addr), 0);
        chk("arst_run", 32'(running), 0);
        chk("arst_act", 32'(ch_active), 0);
        chk("arst_pps", 32'(pps_out), 0);
        #10;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_frame_sched.md
Name: msg_frame_sched

Overview:
Multi-channel frame scheduler for the message transmitter. Locks frame timing to the system PPS. Produces the P-code chip address, repeat index and message bit address consumed by the message generator. New over the previous controller:
- PPS holdover (free-running after lost PPS, with a bounded second count)
- per-channel enables latched at frame boundaries
- parametrised channel count and PPS output pulse width

Parameters:
NUM_CH, 8, number of message channels
PCODE_LEN, 40920, chips per P-code period
PCODE_REPEATS, 10, P-code periods per message bit
MESSAGE_LEN, 120, message bits per frame (one frame = one second)
PPS_WIDTH, 4092000, pps_out high time in clk cycles (>=1)
MAX_HOLDOVER, 5, seconds of free-run allowed without sys_pps (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
sys_time_sync_done  in  1  UTC timer locked
sys_pps  in  1  one-cycle PPS pulse from timer
dac_valid  in  1  advance strobe, one chip per assertion
channel_enable  in  NUM_CH  requested channel enables
pcode_addr  out  clog2(PCODE_LEN)  chip index
rep_idx  out  clog2(PCODE_REPEATS)  repeat index
msg_addr  out  clog2(MESSAGE_LEN)  message bit index
ch_active  out  NUM_CH  enables in force for current frame
frame_start  out  1  one-cycle pulse at frame origin
running  out  1  state is RUN or HOLDOVER
holdover  out  1  state is HOLDOVER
holdover_secs  out  clog2(MAX_HOLDOVER+1)  seconds spent in holdover
pps_out  out  1  stretched PPS

Behaviour:
- Reset (rst, asynchronous, active-high; clock clk):
  - all outputs 0
  - state IDLE
  - pps width counter 0
- States: IDLE, ARMED, RUN, HOLDOVER.
  - IDLE -> ARMED when sys_time_sync_done=1.
  - ARMED -> RUN on sys_pps.
  - Any state -> IDLE when sys_time_sync_done=0. This has priority over everything else. Counters clear. pps_out completes its current pulse.
- Frame origin event (FO): sys_pps in ARMED/RUN/HOLDOVER.
  - Registered: at cycle N+1 after sys_pps at cycle N, pcode_addr=rep_idx=msg_addr=0 and frame_start=1.
  - ch_active <= channel_enable sampled at cycle N.
  - FO in HOLDOVER -> RUN, holdover_secs <= 0.
- Counting (RUN/HOLDOVER, no FO, dac_valid=1):
  - pcode_addr increments, wrapping at PCODE_LEN-1 to 0.
  - On that wrap, rep_idx increments, wrapping at PCODE_REPEATS-1.
  - On rep wrap, msg_addr increments.
  - dac_valid=0 holds all counters.
- Natural wrap (NW): all three counters at their max and dac_valid=1. Next cycle counters are 0, frame_start=1 and ch_active re-latches.
  - NW in RUN -> HOLDOVER, holdover_secs <= 1, synthetic PPS fires.
  - NW in HOLDOVER with holdover_secs < MAX_HOLDOVER: holdover_secs increments, synthetic PPS fires.
  - NW in HOLDOVER with holdover_secs == MAX_HOLDOVER -> IDLE, no synthetic PPS.
  - FO and NW in the same cycle: FO wins (RUN, single frame_start).
- ch_active changes only at frame_start. channel_enable changes mid-frame have no effect until the next origin. ch_active is 0 in IDLE/ARMED.
- pps_out:
  - Rises the cycle after sys_pps or a synthetic PPS, and is held for exactly PPS_WIDTH cycles.
  - A retrigger while high restarts the count.
  - Independent of state except reset.
- Width rules:
  - Counters are unsigned.
  - All compare constants are sized to the counter width, with no truncation for legal parameters.
  - Elaboration check: PCODE_LEN, PCODE_REPEATS, MESSAGE_LEN >= 2.

Decomposition:
- Package msg_sched_pkg: state enum (IDLE/ARMED/RUN/HOLDOVER) and width localparam functions (PC_W, REP_W, MSG_W, HO_W).
- One sub-module, pps_stretcher, holds the PPS_WIDTH retriggerable pulse counter. Scheduler FSM and address counters stay in msg_frame_sched.

Test Plan:
All tests use PCODE_LEN=4, PCODE_REPEATS=2, MESSAGE_LEN=3 (24 valid chips per frame), PPS_WIDTH=3, MAX_HOLDOVER=2.
- Lock: sync_done=1, sys_pps, then continuous dac_valid -> running=1; frame_start one cycle after pps; pcode_addr 0,1,2,3,0; rep_idx 1 after 4 valids; msg_addr 1 after 8 valids; pps_out high exactly 3 cycles.
- Resync: sys_pps after 10 valids -> counters 0 next cycle, single frame_start, holdover stays 0.
- Holdover: no sys_pps for 24 valids -> holdover=1, holdover_secs=1, pps_out pulse. After another 24 valids -> holdover_secs=2. After another 24 -> IDLE, running=0, no pps pulse. Repeat, with sys_pps arriving at holdover_secs=1 -> RUN, holdover_secs=0.
- Enable latching: channel_enable 0x0F->0xF0 mid-frame -> ch_active stays 0x0F until the next frame_start, then 0xF0.
- Simultaneous: sys_pps in the same cycle as the natural wrap -> one frame_start, state RUN, holdover=0.
- Mid-operation: sync_done drop or rst asserted mid-frame -> IDLE, all counters 0, ch_active 0 immediately (rst asynchronous); pps_out cleared by rst only.
